// File: rtl/fb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter_pkg
// Description : Shared types and constants for the framebuffer arbiter and
//               the display timing block's fetch-request logic.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_arbiter_pkg;

  // Arbiter states: the port is either free for draw writes or owned by a
  // line-fetch burst.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } arb_state_t;

  // Cycles from read strobe to valid read data at the RAM port.
  localparam int RD_LAT = 1;

  // Width of line numbers and column indices.
  localparam int LINE_W = 13;

endpackage
`default_nettype wire

// File: rtl/fb_fetch_addr.sv
`default_nettype none
// ============================================================================
// Module      : fb_fetch_addr
// Description : Line-fetch address generator. Latches the line base address,
//               counts the burst column and flags the last column.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_fetch_addr
  import fb_arbiter_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int ADDR_W = 19
) (
  input  logic              i_pixclk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [LINE_W-1:0] i_fetch_line,
  output logic [LINE_W-1:0] o_col,
  output logic [ADDR_W-1:0] o_next_addr,
  output logic              o_last
);

  localparam logic [LINE_W-1:0] c_last_col = LINE_W'(H_RES - 1);

  logic [ADDR_W-1:0] w_line_base;
  logic [LINE_W-1:0] w_col_inc;
  logic [ADDR_W-1:0] r_base;
  logic [LINE_W-1:0] r_col;

  // Product is formed at address width so it wraps modulo 2^ADDR_W.
  assign w_line_base = ADDR_W'(i_fetch_line) * ADDR_W'(H_RES);
  assign w_col_inc   = r_col + LINE_W'(1);

  // A new burst starts at the line base; otherwise the next read is base+col+1.
  assign o_next_addr = i_load ? w_line_base : (r_base + ADDR_W'(w_col_inc));
  assign o_last      = (r_col == c_last_col);
  assign o_col       = r_col;

  // Base latch and column counter; col tracks the read currently on the port.
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base <= '0;
      r_col  <= '0;
    end else if (i_load) begin
      r_base <= w_line_base;
      r_col  <= '0;
    end else if (i_step) begin
      r_col  <= w_col_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter
// Description : Single-port framebuffer arbiter. Display line fetches get
//               absolute priority as one back-to-back burst; draw writes use
//               every other cycle. Read data is returned with its column.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              i_pixclk,
  input  logic              i_rst_n,
  input  logic              i_fetch_start,
  input  logic [LINE_W-1:0] i_fetch_line,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_pix_valid,
  output logic [DATA_W-1:0] o_pix_data,
  output logic [LINE_W-1:0] o_pix_col,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [31:0] c_v_res = V_RES;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_line_ok;
  logic              w_load;
  logic              w_step;
  logic              w_issue_rd;
  logic              w_err_set;
  logic              w_wr_fire;
  logic              w_last;
  logic [ADDR_W-1:0] w_next_addr;
  logic [LINE_W-1:0] w_col;
  logic [RD_LAT-1:0] r_rd_vld;
  logic [LINE_W-1:0] r_rd_col [RD_LAT];

  assign w_line_ok  = (32'(i_fetch_line) < c_v_res);
  // Fetch request wins the port in the same cycle; nothing is ready in reset.
  assign o_wr_ready = i_rst_n & (r_state == ST_IDLE) & ~i_fetch_start;
  assign w_wr_fire  = i_wr_valid & o_wr_ready;
  assign o_busy     = (r_state == ST_FETCH);

  fb_fetch_addr #(
    .H_RES  (H_RES),
    .ADDR_W (ADDR_W)
  ) u_fetch_addr (
    .i_pixclk     (i_pixclk),
    .i_rst_n      (i_rst_n),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_fetch_line (i_fetch_line),
    .o_col        (w_col),
    .o_next_addr  (w_next_addr),
    .o_last       (w_last)
  );

  // State register.
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: accept in-range fetches in IDLE, stream until last column.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_issue_rd  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_fetch_start) begin
          if (w_line_ok) begin
            w_load      = 1'b1;
            w_issue_rd  = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_err_set   = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        // A request during a burst is an overrun; the burst carries on.
        if (i_fetch_start) w_err_set = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step      = 1'b1;
          w_issue_rd  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered memory port; read and write are mutually exclusive by state.
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_re    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else if (w_issue_rd) begin
      o_mem_re    <= 1'b1;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= w_next_addr;
    end else if (w_wr_fire) begin
      o_mem_re    <= 1'b0;
      o_mem_we    <= 1'b1;
      o_mem_addr  <= i_wr_addr;
      o_mem_wdata <= i_wr_data;
    end else begin
      o_mem_re    <= 1'b0;
      o_mem_we    <= 1'b0;
    end
  end

  // Sticky error for out-of-range lines and overruns.
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n)       o_err <= 1'b0;
    else if (w_err_set) o_err <= 1'b1;
  end

  // Delay line aligning read strobe and column with the RAM's read data.
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_rd_col[i] <= '0;
    end else begin
      r_rd_vld[0] <= o_mem_re;
      r_rd_col[0] <= w_col;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_col[i] <= r_rd_col[i-1];
      end
    end
  end

  // Pixel output register.
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_valid <= 1'b0;
      o_pix_data  <= '0;
      o_pix_col   <= '0;
    end else begin
      o_pix_valid <= r_rd_vld[RD_LAT-1];
      if (r_rd_vld[RD_LAT-1]) begin
        o_pix_data <= i_mem_rdata;
        o_pix_col  <= r_rd_col[RD_LAT-1];
      end
    end
  end

endmodule
`default_nettype wire
